u_rf_wb_arb: RTL and testbench

//  Write-back arbiter for the 32x32 integer register file's single write port (rd_e/rd_a/rd_i).
//  Two producers share the port through per-source FIFOs with valid/ready handshakes:
//  ALU pipe (alu_*) and load/store unit (lsu_*). A registered grant drives the regfile.

---
 rtl/u_rf_wb_arb_if.sv | 33 +++
 rtl/u_rf_wb_arb.sv | 143 ++++++++++++++
 tb/tb_u_rf_wb_arb.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/u_rf_wb_arb_if.sv
// Bundle of the write-back arbiter's producer, regfile-port and scoreboard signals.
// Producers and the regfile side connect through the master modport; the arbiter uses slave.
interface u_rf_wb_arb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // Handshake: a request transfers at a rising edge where x_v & x_r are both high;
    // the producer holds x_v/x_a/x_d stable until that edge, and x_r never depends on x_v.
    logic          flush;
    logic          alu_v;
    logic          alu_r;
    logic [AW-1:0] alu_a;
    logic [DW-1:0] alu_d;
    logic          lsu_v;
    logic          lsu_r;
    logic [AW-1:0] lsu_a;
    logic [DW-1:0] lsu_d;
    logic          rd_e;
    logic [AW-1:0] rd_a;
    logic [DW-1:0] rd_i;
    logic [31:0]   pend_o;
    logic          busy_o;

    modport master (
        output flush, alu_v, alu_a, alu_d, lsu_v, lsu_a, lsu_d,
        input  alu_r, lsu_r, rd_e, rd_a, rd_i, pend_o, busy_o
    );

    modport slave (
        input  flush, alu_v, alu_a, alu_d, lsu_v, lsu_a, lsu_d,
        output alu_r, lsu_r, rd_e, rd_a, rd_i, pend_o, busy_o
    );
endinterface

// File: rtl/u_rf_wb_arb.sv
// Register-file write-back arbiter: ALU and LSU FIFOs share one registered write port.
// Define U_RF_WB_RR_EN for round-robin arbitration; default is fixed priority LSU over ALU.
module u_rf_wb_arb #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           rst,
    u_rf_wb_arb_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    // Source index 0 is the ALU, 1 is the LSU.
    logic [EW-1:0] mem [2][DEPTH];
    logic [PW-1:0] wp [2];
    logic [PW-1:0] rp [2];
    logic [CW-1:0] cnt [2];
    logic [AW-1:0] src_a [2];
    logic [DW-1:0] src_d [2];
    logic [1:0]    src_v, src_r, full, ne, push, gnt;
    logic [EW-1:0] win;
    logic          rd_e_q;
    logic [AW-1:0] rd_a_q;
    logic [DW-1:0] rd_i_q;
    logic [31:0]   pend;

    assign src_v    = {bus.lsu_v, bus.alu_v};
    assign src_a[0] = bus.alu_a;
    assign src_a[1] = bus.lsu_a;
    assign src_d[0] = bus.alu_d;
    assign src_d[1] = bus.lsu_d;

    always_comb begin
        full  = '0;
        ne    = '0;
        src_r = '0;
        push  = '0;
        for (int s = 0; s < 2; s++) begin
            full[s]  = (cnt[s] == CW'(DEPTH));
            ne[s]    = (cnt[s] != '0);
            src_r[s] = !full[s] && !bus.flush && !rst;
            // x0 writes complete the handshake but are discarded here.
            push[s]  = src_v[s] && src_r[s] && (src_a[s] != '0);
        end
    end

`ifdef U_RF_WB_RR_EN
    logic rr_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_alu <= 1'b1;
        else if (gnt[1]) rr_alu <= 1'b1;
        else if (gnt[0]) rr_alu <= 1'b0;
    end

    always_comb begin
        gnt = ne;
        if (ne[0] && ne[1]) gnt = rr_alu ? 2'b01 : 2'b10;
        if (bus.flush)      gnt = 2'b00;
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (ne[1])      gnt = 2'b10;
        else if (ne[0]) gnt = 2'b01;
        if (bus.flush)  gnt = 2'b00;
    end
`endif

    assign win = gnt[1] ? mem[1][rp[1]] : mem[0][rp[0]];

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++)
            if (push[s]) mem[s][wp[s]] <= {src_a[s], src_d[s]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                wp[s]  <= '0;
                rp[s]  <= '0;
                cnt[s] <= '0;
            end
        end else if (bus.flush) begin
            for (int s = 0; s < 2; s++) begin
                wp[s]  <= '0;
                rp[s]  <= '0;
                cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wp[s] <= wp[s] + PW'(1);
                if (gnt[s])  rp[s] <= rp[s] + PW'(1);
                case ({push[s], gnt[s]})
                    2'b10:   cnt[s] <= cnt[s] + CW'(1);
                    2'b01:   cnt[s] <= cnt[s] - CW'(1);
                    default: cnt[s] <= cnt[s];
                endcase
            end
        end
    end

    // Address/data are zeroed when idle so the regfile's forward path reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_e_q <= 1'b0;
            rd_a_q <= '0;
            rd_i_q <= '0;
        end else begin
            rd_e_q <= |gnt;
            rd_a_q <= (|gnt) ? win[EW-1:DW] : '0;
            rd_i_q <= (|gnt) ? win[DW-1:0]  : '0;
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        logic [EW-1:0] ent;
        pend = '0;
        idx  = '0;
        ent  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rp[s] + PW'(i);
                ent = mem[s][idx];
                if (CW'(i) < cnt[s]) pend[ent[EW-1:DW]] = 1'b1;
            end
        end
        if (rd_e_q) pend[rd_a_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign bus.alu_r  = src_r[0];
    assign bus.lsu_r  = src_r[1];
    assign bus.rd_e   = rd_e_q;
    assign bus.rd_a   = rd_a_q;
    assign bus.rd_i   = rd_i_q;
    assign bus.pend_o = pend;
    assign bus.busy_o = (cnt[0] != '0) || (cnt[1] != '0) || rd_e_q;
endmodule

// File: tb/tb_u_rf_wb_arb.sv
// Bench for u_rf_wb_arb: directed cycle table, randomized traffic against a queue model,
// and an asynchronous reset while writes are queued.
module tb_u_rf_wb_arb;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int EW    = AW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  u_rf_wb_arb_if #(.AW(AW), .DW(DW)) bus ();
  u_rf_wb_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          lv;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          fl;
    logic          e_ar;
    logic          e_lr;
    logic          e_rde;
    logic [AW-1:0] e_rda;
    logic [DW-1:0] e_rdi;
    logic [31:0]   e_pend;
    logic          e_busy;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: per-source queues of {addr, data} and the registered write port.
  logic [EW-1:0] alu_q[$];
  logic [EW-1:0] lsu_q[$];
  logic          m_e;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic          rr_alu;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                              input logic fl, input logic ear, input logic elr, input logic erde,
                              input logic [AW-1:0] erda, input logic [DW-1:0] erdi,
                              input logic [31:0] epend, input logic ebusy);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld; v.fl = fl;
    v.e_ar = ear; v.e_lr = elr; v.e_rde = erde; v.e_rda = erda; v.e_rdi = erdi;
    v.e_pend = epend; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic model_clear();
    alu_q.delete();
    lsu_q.delete();
    m_e = 1'b0; m_a = '0; m_d = '0;
    rr_alu = 1'b1;
  endtask

  // One cycle: compare at the falling edge, advance the model for the coming rising edge.
  task automatic model_step(input string tag, output logic a_acc, output logic l_acc);
    logic e_ar, e_lr, g_alu, g_lsu;
    logic [31:0] e_pend;
    logic [EW-1:0] w;
    @(negedge clk);
    e_ar = !bus.flush && (alu_q.size() < DEPTH);
    e_lr = !bus.flush && (lsu_q.size() < DEPTH);
    e_pend = '0;
    foreach (alu_q[i]) e_pend[alu_q[i][EW-1:DW]] = 1'b1;
    foreach (lsu_q[i]) e_pend[lsu_q[i][EW-1:DW]] = 1'b1;
    if (m_e) e_pend[m_a] = 1'b1;
    chk({tag, ".alu_r"}, 32'(bus.alu_r), 32'(e_ar));
    chk({tag, ".lsu_r"}, 32'(bus.lsu_r), 32'(e_lr));
    chk({tag, ".rd_e"},  32'(bus.rd_e),  32'(m_e));
    chk({tag, ".rd_a"},  32'(bus.rd_a),  32'(m_a));
    chk({tag, ".rd_i"},  bus.rd_i,       m_d);
    chk({tag, ".pend"},  bus.pend_o,     e_pend);
    chk({tag, ".busy"},  32'(bus.busy_o),
        32'((alu_q.size() != 0) || (lsu_q.size() != 0) || m_e));
    a_acc = bus.alu_v && e_ar;
    l_acc = bus.lsu_v && e_lr;
    if (bus.flush) begin
      alu_q.delete();
      lsu_q.delete();
      m_e = 1'b0; m_a = '0; m_d = '0;
    end else begin
      g_lsu = (lsu_q.size() != 0);
      g_alu = (alu_q.size() != 0);
`ifdef U_RF_WB_RR_EN
      if (g_lsu && g_alu) begin
        if (rr_alu) g_lsu = 1'b0;
        else        g_alu = 1'b0;
      end
`else
      if (g_lsu) g_alu = 1'b0;
`endif
      if (g_lsu) begin
        w = lsu_q.pop_front(); rr_alu = 1'b1;
      end else if (g_alu) begin
        w = alu_q.pop_front(); rr_alu = 1'b0;
      end else begin
        w = '0;
      end
      m_e = g_lsu || g_alu;
      m_a = w[EW-1:DW];
      m_d = w[DW-1:0];
      if (a_acc && bus.alu_a != '0) alu_q.push_back({bus.alu_a, bus.alu_d});
      if (l_acc && bus.lsu_a != '0) lsu_q.push_back({bus.lsu_a, bus.lsu_d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic fl);
    bus.alu_v = av; bus.alu_a = aa; bus.alu_d = ad;
    bus.lsu_v = lv; bus.lsu_a = la; bus.lsu_d = ld;
    bus.flush = fl;
  endtask

  vec_t tbl[27];
  logic a_acc, l_acc;
  logic r_av, r_lv;
  logic [AW-1:0] r_aa, r_la;
  logic [DW-1:0] r_ad, r_ld;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #2;
    chk("reset.rd_e",  32'(bus.rd_e),   32'h0);
    chk("reset.rd_a",  32'(bus.rd_a),   32'h0);
    chk("reset.rd_i",  bus.rd_i,        32'h0);
    chk("reset.pend",  bus.pend_o,      32'h0);
    chk("reset.busy",  32'(bus.busy_o), 32'h0);
    chk("reset.alu_r", 32'(bus.alu_r),  32'h0);
    chk("reset.lsu_r", 32'(bus.lsu_r),  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifndef U_RF_WB_RR_EN
    //               av aa ad            lv la ld     fl ar lr rde rda rdi           pend          busy
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h20,       1);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 5, 32'hDEADBEEF, 32'h20,       1);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[4]  = mk(1, 0, 32'h1234,     0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[6]  = mk(1, 1, 32'hA1,       1, 1, 32'hB1, 0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[7]  = mk(1, 2, 32'hA2,       1, 2, 32'hB2, 0, 1, 1, 0, 0, 32'h0,        32'h2,        1);
    tbl[8]  = mk(1, 3, 32'hA3,       1, 3, 32'hB3, 0, 0, 1, 1, 1, 32'hB1,       32'h6,        1);
    tbl[9]  = mk(1, 3, 32'hA3,       0, 0, 0,     0, 0, 1, 1, 2, 32'hB2,       32'hE,        1);
    tbl[10] = mk(1, 3, 32'hA3,       0, 0, 0,     0, 0, 1, 1, 3, 32'hB3,       32'hE,        1);
    tbl[11] = mk(1, 3, 32'hA3,       0, 0, 0,     0, 1, 1, 1, 1, 32'hA1,       32'h6,        1);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 2, 32'hA2,       32'hC,        1);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 3, 32'hA3,       32'h8,        1);
    tbl[14] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[15] = mk(0, 0, 0,            1, 7, 1,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[16] = mk(0, 0, 0,            1, 7, 2,     0, 1, 1, 0, 0, 32'h0,        32'h80,       1);
    tbl[17] = mk(0, 0, 0,            1, 8, 3,     0, 1, 1, 1, 7, 32'h1,        32'h80,       1);
    tbl[18] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 7, 32'h2,        32'h180,      1);
    tbl[19] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 8, 32'h3,        32'h100,      1);
    tbl[20] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[21] = mk(1, 9, 9,            1, 10, 10,   0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[22] = mk(1, 11, 11,          1, 12, 12,   0, 1, 1, 0, 0, 32'h0,        32'h600,      1);
    tbl[23] = mk(1, 13, 13,          1, 14, 14,   1, 0, 0, 1, 10, 32'hA,       32'h1E00,     1);
    tbl[24] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[25] = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 0, 0, 32'h0,        32'h0,        0);
    tbl[26] = mk(0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 32'h0,        32'h0,        0);
    for (int r = 0; r < 27; r++) begin
      drive(tbl[r].av, tbl[r].aa, tbl[r].ad, tbl[r].lv, tbl[r].la, tbl[r].ld, tbl[r].fl);
      @(negedge clk);
      chk($sformatf("t%0d.alu_r", r), 32'(bus.alu_r),  32'(tbl[r].e_ar));
      chk($sformatf("t%0d.lsu_r", r), 32'(bus.lsu_r),  32'(tbl[r].e_lr));
      chk($sformatf("t%0d.rd_e", r),  32'(bus.rd_e),   32'(tbl[r].e_rde));
      chk($sformatf("t%0d.rd_a", r),  32'(bus.rd_a),   32'(tbl[r].e_rda));
      chk($sformatf("t%0d.rd_i", r),  bus.rd_i,        tbl[r].e_rdi);
      chk($sformatf("t%0d.pend", r),  bus.pend_o,      tbl[r].e_pend);
      chk($sformatf("t%0d.busy", r),  32'(bus.busy_o), 32'(tbl[r].e_busy));
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic: requests are held until the model says they were accepted.
    r_av = 1'b0; r_lv = 1'b0;
    r_aa = '0; r_la = '0; r_ad = '0; r_ld = '0;
    a_acc = 1'b1; l_acc = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (!r_av || a_acc) begin
        r_av = ($urandom_range(0, 3) != 0);
        r_aa = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
        r_ad = $urandom;
      end
      if (!r_lv || l_acc) begin
        r_lv = ($urandom_range(0, 3) != 0);
        r_la = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
        r_ld = $urandom;
      end
      drive(r_av, r_aa, r_ad, r_lv, r_la, r_ld, ($urandom_range(0, 24) == 0));
      model_step($sformatf("rnd%0d", c), a_acc, l_acc);
    end

    // Queue writes from both sources, then reset asynchronously mid-operation.
    drive(0, 0, 0, 0, 0, 0, 1);
    model_step("pre_flush", a_acc, l_acc);
    for (int c = 0; c < 4; c++) begin
      drive(1, 3, 32'h33, 1, 4, 32'h44, 0);
      model_step($sformatf("fill%0d", c), a_acc, l_acc);
    end
    rst = 1'b1;
    #1;
    chk("midrst.rd_e",  32'(bus.rd_e),   32'h0);
    chk("midrst.pend",  bus.pend_o,      32'h0);
    chk("midrst.busy",  32'(bus.busy_o), 32'h0);
    chk("midrst.alu_r", 32'(bus.alu_r),  32'h0);
    chk("midrst.lsu_r", 32'(bus.lsu_r),  32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) model_step($sformatf("post_rst%0d", c), a_acc, l_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
